block_ram_sdp_ctrl: RTL
=======================

Name: block_ram_sdp_ctrl

Overview:
Parametrised simple-dual-port block RAM: one write port and one read port on a single clock.
- Write port has per-byte write enables.
- Read-during-write collision mode is selectable.
- Optional output register adds a pipeline stage; a valid flag tracks read latency.
- Built-in clear engine zeroes the array after reset or on request.
- Serves as the general storage primitive for line buffers and coefficient tables in the datapath.

Parameters:
- ADDR_WIDTH, 8, address bits; DEPTH = 2^ADDR_WIDTH words.
- DATA_WIDTH, 32, word width; must be a multiple of 8.
- OUT_REG, 0, 1 adds an output register stage (read latency 2 instead of 1).
- RDW_MODE, 0, same-address read/write in one cycle: 0 = read-first (old data), 1 = write-first (new merged data).
- CLEAR_ON_RESET, 1, 1 starts a clear sweep automatically when reset deasserts.

Ports:
- clk, input, 1, clock; all logic on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- wr_en, input, 1, write request.
- wr_addr, input, ADDR_WIDTH, write address.
- wr_data, input, DATA_WIDTH, write data.
- wr_be, input, DATA_WIDTH/8, byte enables; bit i covers wr_data[8i+7:8i].
- rd_en, input, 1, read request.
- rd_addr, input, ADDR_WIDTH, read address.
- rd_data, output, DATA_WIDTH, read data.
- rd_valid, output, 1, rd_data carries the result of an accepted read this cycle.
- clr_start, input, 1, one-cycle pulse requesting a full clear.
- busy, output, 1, clear sweep in progress; user ports ignored.

Behaviour:
- Reset (async assert, sync release):
  - rd_data = 0, rd_valid = 0, and the internal pipeline valid/data registers = 0.
  - FSM enters CLEAR if CLEAR_ON_RESET = 1, else IDLE; busy reflects the FSM state immediately while rst_n is low.
  - Array contents are not reset directly.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR on clr_start = 1.
  - CLEAR writes 0 to clr_cnt, increments clr_cnt each cycle starting from 0, and moves to IDLE the cycle after writing DEPTH-1.
  - A sweep therefore takes exactly DEPTH cycles with busy = 1.
  - busy = 1 exactly when state == CLEAR.
- While busy:
  - wr_en and rd_en are ignored; no user write occurs and no read is accepted.
  - rd_valid stays 0.
  - clr_start is ignored.
- Reset mid-sweep aborts the sweep, clears clr_cnt, and re-enters per CLEAR_ON_RESET. A partially cleared array is acceptable only when CLEAR_ON_RESET = 0.
- Write: when wr_en && !busy, byte i of mem[wr_addr] takes wr_data byte i where wr_be[i] = 1; other bytes are unchanged. wr_be = 0 performs no write.
- Read is accepted when rd_en && !busy.
  - OUT_REG = 0: rd_data is updated at the next edge and rd_valid = 1 for that cycle.
  - OUT_REG = 1: both appear one cycle later.
  - Back-to-back reads every cycle yield rd_valid continuously high at full throughput.
- rd_data holds its last value when no read completes; rd_valid then = 0.
- Collision (rd_en && wr_en && rd_addr == wr_addr, not busy):
  - RDW_MODE 0: returns the pre-write word.
  - RDW_MODE 1: returns the post-write word, i.e. enabled bytes from wr_data and the rest from the old word.
  - Different addresses never interact.
- Address wrap: addresses are ADDR_WIDTH bits; no out-of-range case exists.

Test Plan:
- Reset with CLEAR_ON_RESET = 1, ADDR_WIDTH = 4 -> busy high for exactly 16 cycles after rst_n rises; then reading all 16 addresses returns 0 with rd_valid one cycle after each rd_en (OUT_REG = 0).
- Write 0xDEADBEEF to addr 5 with wr_be = 4'b1111, then write 0x11223344 with wr_be = 4'b0101, then read addr 5 -> 0xDE22BE44.
- RDW_MODE = 0: addr 3 holds 0xAAAA5555; same-cycle write 0x12345678 (all bytes) and read of addr 3 -> rd_data = 0xAAAA5555, and the following read returns 0x12345678. RDW_MODE = 1, same stimulus -> first read returns 0x12345678.
- OUT_REG = 1: reads issued on 4 consecutive cycles to addrs 0..3 holding 10, 11, 12, 13 -> rd_valid high for 4 consecutive cycles starting 2 cycles after the first rd_en, with data 10, 11, 12, 13 in order.
- Pulse clr_start after filling memory; drive wr_en/rd_en during the sweep -> busy for DEPTH cycles, rd_valid stays 0, no user write lands, and all words read 0 afterwards. A second clr_start mid-sweep does not extend it.
- Assert rst_n low at cycle 7 of a sweep -> busy, rd_valid and rd_data go to reset values asynchronously; the sweep restarts from address 0 on release and again lasts DEPTH cycles.

Source files
------------

// File: rtl/block_ram_sdp_ctrl.sv
// Simple-dual-port block RAM with byte-enabled writes, selectable read-during-write
// behaviour, optional output register and a built-in clear sweep engine.
module block_ram_sdp_ctrl #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int OUT_REG        = 0,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_be,
    input  logic                    rd_en,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid,
    input  logic                    clr_start,
    output logic                    busy
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int NB    = DATA_WIDTH / 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   clr_cnt;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    wr_fire;
    logic                    rd_fire;
    logic                    collide;
    logic [DATA_WIDTH-1:0]   old_word;
    logic [DATA_WIDTH-1:0]   merged_word;
    logic [DATA_WIDTH-1:0]   read_word;

    assign busy    = (state == ST_CLEAR);
    assign wr_fire = wr_en && !busy;
    assign rd_fire = rd_en && !busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RST_STATE;
            clr_cnt <= '0;
        end else begin
            state <= state_next;
            // The counter wraps to zero on its own after the last address.
            if (state == ST_CLEAR) begin
                clr_cnt <= clr_cnt + 1'b1;
            end else begin
                clr_cnt <= '0;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (clr_start) state_next = ST_CLEAR;
            ST_CLEAR: if (&clr_cnt)  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (busy) begin
            mem[clr_cnt] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    assign old_word = mem[rd_addr];
    assign collide  = wr_fire && (wr_addr == rd_addr);

    always_comb begin
        merged_word = old_word;
        for (int i = 0; i < NB; i++) begin
            if (wr_be[i]) merged_word[8*i +: 8] = wr_data[8*i +: 8];
        end
    end

    // Write-first returns the word as it will look after this cycle's write.
    assign read_word = ((RDW_MODE != 0) && collide) ? merged_word : old_word;

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic                  pipe_valid;
            logic [DATA_WIDTH-1:0] pipe_data;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pipe_valid <= 1'b0;
                    pipe_data  <= '0;
                    rd_valid   <= 1'b0;
                    rd_data    <= '0;
                end else begin
                    pipe_valid <= rd_fire;
                    if (rd_fire) pipe_data <= read_word;
                    rd_valid <= pipe_valid;
                    if (pipe_valid) rd_data <= pipe_data;
                end
            end
        end else begin : g_no_out_reg
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_valid <= 1'b0;
                    rd_data  <= '0;
                end else begin
                    rd_valid <= rd_fire;
                    if (rd_fire) rd_data <= read_word;
                end
            end
        end
    endgenerate

endmodule
